// File: rtl/sonic_sync_ring_ctrl.sv
// -----------------------------------------------------------------------------
// sonic_sync_ring_ctrl
//
// Read-side controller for the TX sync-header ring. The DMA side writes
// 128-bit words into the ring. Each word holds 64 two-bit sync headers. The
// TX encoder reads the ring one header at a time. This block:
//   - counts committed words against consumed headers,
//   - drives the ring read address,
//   - holds off reads until a prefill threshold is reached,
//   - produces a valid strobe aligned to the ring read latency,
//   - reports the DMA free-space credit,
//   - keeps sticky underflow and overflow flags.
//
// Optional feature macro: SONIC_SYNC_RING_STATS_EN
//   When defined, the block adds the stats_clear input and the hdr_count and
//   underflow_count outputs.
//
// Ports:
//   clock           in   sole clock (ring read clock)
//   reset_n         in   asynchronous active-low reset
//   enable          in   run request from the TX path
//   clear           in   synchronous flush of pointers, flags and state
//   wr_commit       in   one further 128-bit word has been written
//   rd_req          in   encoder requests the next header
//   rd_address      out  header read address to the ring
//   rd_ack          out  rd_req accepted this cycle (combinational)
//   hdr_valid       out  ring data_out carries an accepted header
//   level           out  unread headers in the ring
//   free_words      out  words the DMA may still write
//   running         out  controller is in RUN
//   underflow       out  sticky: request while empty in RUN
//   overflow        out  sticky: commit while full
//   stats_clear     in   (stats build) clear the statistics counters
//   hdr_count       out  (stats build) accepted headers, wrapping
//   underflow_count out  (stats build) underflow events, saturating
// -----------------------------------------------------------------------------
module sonic_sync_ring_ctrl #(
    parameter int WR_ADDR_WIDTH = 9,
    parameter int RD_ADDR_WIDTH = WR_ADDR_WIDTH + 6,
    parameter int RD_LAT        = 2,
    parameter int PREFILL_WORDS = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     wr_commit,
    input  logic                     rd_req,
    output logic [RD_ADDR_WIDTH-1:0] rd_address,
    output logic                     rd_ack,
    output logic                     hdr_valid,
    output logic [RD_ADDR_WIDTH:0]   level,
    output logic [WR_ADDR_WIDTH:0]   free_words,
    output logic                     running,
    output logic                     underflow,
`ifdef SONIC_SYNC_RING_STATS_EN
    output logic                     overflow,
    input  logic                     stats_clear,
    output logic [31:0]              hdr_count,
    output logic [15:0]              underflow_count
`else
    output logic                     overflow
`endif
);

    localparam logic [WR_ADDR_WIDTH:0] DEPTH_WORDS = {1'b1, {WR_ADDR_WIDTH{1'b0}}};
    localparam logic [WR_ADDR_WIDTH:0] PREFILL     = (WR_ADDR_WIDTH + 1)'(PREFILL_WORDS);
    localparam logic [WR_ADDR_WIDTH:0] WR_ONE      = (WR_ADDR_WIDTH + 1)'(1);
    localparam logic [RD_ADDR_WIDTH:0] RD_ONE      = (RD_ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;

    logic [WR_ADDR_WIDTH:0]   wr_ptr;
    logic [RD_ADDR_WIDTH:0]   rd_ptr;
    logic [WR_ADDR_WIDTH:0]   used_words;
    logic                     level_nz;
    logic                     ring_full;
    logic                     wr_accept;
    logic                     overflow_evt;
    logic                     underflow_evt;
    logic [RD_LAT-1:0]        vld_p;

    // Occupancy. A word is freed only when all 64 of its headers have been
    // read, so the word-granular view uses the upper bits of rd_ptr.
    assign used_words = wr_ptr - rd_ptr[RD_ADDR_WIDTH:6];
    assign free_words = DEPTH_WORDS - used_words;
    assign level      = {wr_ptr, 6'b0} - rd_ptr;
    assign level_nz   = (level != '0);
    assign ring_full  = (free_words == '0);
    assign rd_address = rd_ptr[RD_ADDR_WIDTH-1:0];

    // A commit is judged against the fullness before the edge. A read in the
    // same cycle cannot make room for that commit.
    assign wr_accept    = wr_commit & ~ring_full;
    assign overflow_evt = wr_commit & ring_full;

    // FSM: state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state. Dropping enable wins from every state.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = FILL;
                FILL:    if (used_words >= PREFILL) state_next = RUN;
                RUN:     if (rd_req && !level_nz) state_next = FILL;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM: outputs. A request that finds the ring empty is refused and
    // recorded as an underflow.
    always_comb begin
        running       = (state == RUN);
        rd_ack        = running & rd_req & level_nz;
        underflow_evt = running & rd_req & ~level_nz;
    end

    // Pointers and sticky flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept)     wr_ptr    <= wr_ptr + WR_ONE;
            if (rd_ack)        rd_ptr    <= rd_ptr + RD_ONE;
            if (overflow_evt)  overflow  <= 1'b1;
            if (underflow_evt) underflow <= 1'b1;
        end
    end

    // Valid pipeline: stage 0 is the ack delayed by one edge. The last stage
    // lines up with the ring read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p <= '0;
        end else if (clear) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_ack;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign hdr_valid = vld_p[RD_LAT-1];

`ifdef SONIC_SYNC_RING_STATS_EN
    // Statistics: the header count wraps, while the underflow count sticks
    // at its maximum.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hdr_count       <= '0;
            underflow_count <= '0;
        end else if (clear || stats_clear) begin
            hdr_count       <= '0;
            underflow_count <= '0;
        end else begin
            if (rd_ack) hdr_count <= hdr_count + 32'd1;
            if (underflow_evt && (underflow_count != 16'hFFFF)) begin
                underflow_count <= underflow_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sonic_sync_ring_ctrl.sv
module tb_sonic_sync_ring_ctrl;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        clear;
    logic        wr_commit;
    logic        rd_req;
    logic [14:0] rd_address;
    logic        rd_ack;
    logic        hdr_valid;
    logic [15:0] level;
    logic [9:0]  free_words;
    logic        running;
    logic        underflow;
    logic        overflow;

    int vectors;
    int miscompares;

    sonic_sync_ring_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear      (clear),
        .wr_commit  (wr_commit),
        .rd_req     (rd_req),
        .rd_address (rd_address),
        .rd_ack     (rd_ack),
        .hdr_valid  (hdr_valid),
        .level      (level),
        .free_words (free_words),
        .running    (running),
        .underflow  (underflow),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic commit_words(input int n);
        wr_commit = 1'b1;
        repeat (n) tick();
        wr_commit = 1'b0;
    endtask

    task automatic wait_running();
        int n;
        n = 0;
        while (running !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        vectors++;
        if (running !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_running: running=%0b required 1 after %0d cycles", running, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; clear = 1'b0; wr_commit = 1'b0; rd_req = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        vectors++; if (rd_address !== 15'd0) begin miscompares++; $display("FAIL reset_rd_address: got %0d want 0", rd_address); end
        vectors++; if (rd_ack !== 1'b0) begin miscompares++; $display("FAIL reset_rd_ack: got %0b want 0", rd_ack); end
        vectors++; if (hdr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_hdr_valid: got %0b want 0", hdr_valid); end
        vectors++; if (level !== 16'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", level); end
        vectors++; if (free_words !== 10'd512) begin miscompares++; $display("FAIL reset_free_words: got %0d want 512", free_words); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL reset_running: got %0b want 0", running); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow: got %0b want 0", underflow); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    endtask

    task automatic test_prefill();
        enable = 1'b1;
        tick();                         // IDLE -> FILL
        wr_commit = 1'b1; rd_req = 1'b1;
        @(negedge clock);
        vectors++; if (rd_ack !== 1'b0) begin miscompares++; $display("FAIL prefill_no_ack: rd_ack=%0b want 0", rd_ack); end
        tick();                         // first word committed
        @(negedge clock);
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL prefill_one_word: running=%0b want 0", running); end
        tick();                         // second word committed
        wr_commit = 1'b0;
        @(negedge clock);
        vectors++; if (level !== 16'd128) begin miscompares++; $display("FAIL prefill_level: got %0d want 128", level); end
        vectors++; if (rd_ack !== 1'b0) begin miscompares++; $display("FAIL prefill_still_fill: rd_ack=%0b want 0", rd_ack); end
        tick();                         // FILL -> RUN
        @(negedge clock);
        vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL prefill_run: running=%0b want 1", running); end
        vectors++; if (rd_ack !== 1'b1 || rd_address !== 15'd0) begin miscompares++; $display("FAIL prefill_first_ack: ack=%0b addr=%0d want 1/0", rd_ack, rd_address); end
        tick();
        rd_req = 1'b0;
        @(negedge clock);
        vectors++; if (hdr_valid !== 1'b0 || rd_address !== 15'd1) begin miscompares++; $display("FAIL prefill_t1: valid=%0b addr=%0d want 0/1", hdr_valid, rd_address); end
        tick();
        @(negedge clock);
        vectors++; if (hdr_valid !== 1'b1) begin miscompares++; $display("FAIL prefill_t2_valid: got %0b want 1", hdr_valid); end
        tick();
        @(negedge clock);
        vectors++; if (hdr_valid !== 1'b0) begin miscompares++; $display("FAIL prefill_t3_valid: got %0b want 0", hdr_valid); end
    endtask

    task automatic test_stream();
        do_clear();
        commit_words(2);
        wait_running();
        rd_req = 1'b1;
        for (int i = 0; i < 128; i++) begin
            @(negedge clock);
            vectors++;
            if (rd_ack !== 1'b1 || rd_address !== 15'(i)) begin
                miscompares++;
                $display("FAIL stream_ack[%0d]: ack=%0b addr=%0d want 1/%0d", i, rd_ack, rd_address, i);
            end
            tick();
            if (i == 63) begin
                vectors++;
                if (free_words !== 10'd511) begin miscompares++; $display("FAIL stream_free_mid: got %0d want 511", free_words); end
            end
        end
        vectors++; if (free_words !== 10'd512) begin miscompares++; $display("FAIL stream_free_end: got %0d want 512", free_words); end
        vectors++; if (level !== 16'd0) begin miscompares++; $display("FAIL stream_level_end: got %0d want 0", level); end
        @(negedge clock);
        vectors++; if (rd_ack !== 1'b0) begin miscompares++; $display("FAIL stream_empty_ack: got %0b want 0", rd_ack); end
        tick();
        rd_req = 1'b0;
        vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL stream_underflow: got %0b want 1", underflow); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL stream_back_to_fill: running=%0b want 0", running); end
    endtask

    task automatic test_full();
        do_clear();
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL clear_underflow: got %0b want 0", underflow); end
        enable = 1'b0;
        wr_commit = 1'b1;
        repeat (512) tick();
        @(negedge clock);
        vectors++; if (free_words !== 10'd0) begin miscompares++; $display("FAIL full_free: got %0d want 0", free_words); end
        vectors++; if (level !== 16'd32768) begin miscompares++; $display("FAIL full_level: got %0d want 32768", level); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_no_overflow_yet: got %0b want 0", overflow); end
        tick();                         // 513th commit
        wr_commit = 1'b0;
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL full_overflow: got %0b want 1", overflow); end
        vectors++; if (level !== 16'd32768) begin miscompares++; $display("FAIL full_wr_held: level=%0d want 32768", level); end
        enable = 1'b1;
        wait_running();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        vectors++; if (free_words !== 10'd0 || level !== 16'd32767) begin miscompares++; $display("FAIL full_one_read: free=%0d level=%0d want 0/32767", free_words, level); end
        wr_commit = 1'b1; rd_req = 1'b1;
        @(negedge clock);
        vectors++; if (rd_ack !== 1'b1) begin miscompares++; $display("FAIL full_commit_ack: ack=%0b want 1", rd_ack); end
        tick();
        wr_commit = 1'b0;
        vectors++; if (level !== 16'd32766 || free_words !== 10'd0) begin miscompares++; $display("FAIL full_commit_rejected: level=%0d free=%0d want 32766/0", level, free_words); end
        repeat (62) tick();
        rd_req = 1'b0;
        vectors++; if (free_words !== 10'd1) begin miscompares++; $display("FAIL full_word_freed: got %0d want 1", free_words); end
        vectors++; if (level !== 16'd32704) begin miscompares++; $display("FAIL full_level_after_64: got %0d want 32704", level); end
    endtask

    task automatic test_wrap();
        int bad;
        int bad_i;
        logic [14:0] bad_addr;
        logic [15:0] bad_level;
        logic        bad_ack;
        bad = 0; bad_i = 0; bad_addr = '0; bad_level = '0; bad_ack = 1'b0;
        do_clear();
        commit_words(2);
        wait_running();
        rd_req = 1'b1;
        for (int i = 0; i < 38400; i++) begin
            wr_commit = ((i % 64) == 0);
            @(negedge clock);
            if (rd_ack !== 1'b1 || rd_address !== 15'(i) || level > 16'd32768 || level == 16'd0) begin
                if (bad == 0) begin
                    bad_i = i; bad_addr = rd_address; bad_level = level; bad_ack = rd_ack;
                end
                bad++;
            end
            tick();
        end
        wr_commit = 1'b0;
        rd_req = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL wrap_sequence: %0d bad cycles, first at %0d ack=%0b addr=%0d level=%0d want 1/%0d/1..32768",
                     bad, bad_i, bad_ack, bad_addr, bad_level, bad_i % 32768);
        end
        vectors++; if (level !== 16'd128) begin miscompares++; $display("FAIL wrap_level_end: got %0d want 128", level); end
        vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL wrap_underflow: got %0b want 0", underflow); end
    endtask

    task automatic test_simultaneous();
        do_clear();
        commit_words(2);
        wait_running();
        rd_req = 1'b1;
        repeat (118) tick();
        rd_req = 1'b0;
        vectors++; if (level !== 16'd10) begin miscompares++; $display("FAIL simul_level10: got %0d want 10", level); end
        wr_commit = 1'b1; rd_req = 1'b1;
        @(negedge clock);
        vectors++; if (rd_ack !== 1'b1) begin miscompares++; $display("FAIL simul_ack: got %0b want 1", rd_ack); end
        tick();
        vectors++; if (level !== 16'd73) begin miscompares++; $display("FAIL simul_level73: got %0d want 73", level); end
        clear = 1'b1;                   // commit and req still asserted
        tick();
        clear = 1'b0; wr_commit = 1'b0; rd_req = 1'b0;
        vectors++; if (level !== 16'd0 || free_words !== 10'd512 || rd_address !== 15'd0) begin miscompares++; $display("FAIL clear_pointers: level=%0d free=%0d addr=%0d want 0/512/0", level, free_words, rd_address); end
        vectors++; if (running !== 1'b0 || underflow !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL clear_state_flags: run=%0b uf=%0b of=%0b want 0/0/0", running, underflow, overflow); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            vectors++;
            if (hdr_valid !== 1'b0) begin miscompares++; $display("FAIL clear_flush_valid[%0d]: got %0b want 0", i, hdr_valid); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        commit_words(2);
        wait_running();
        rd_req = 1'b1;
        tick();
        tick();
        rd_req = 1'b0;
        vectors++; if (hdr_valid !== 1'b1) begin miscompares++; $display("FAIL areset_inflight: hdr_valid=%0b want 1", hdr_valid); end
        #1 reset_n = 1'b0;
        #1;
        vectors++; if (hdr_valid !== 1'b0 || rd_ack !== 1'b0 || running !== 1'b0) begin miscompares++; $display("FAIL areset_ctrl: valid=%0b ack=%0b run=%0b want 0/0/0", hdr_valid, rd_ack, running); end
        vectors++; if (level !== 16'd0 || free_words !== 10'd512 || rd_address !== 15'd0) begin miscompares++; $display("FAIL areset_ptrs: level=%0d free=%0d addr=%0d want 0/512/0", level, free_words, rd_address); end
        vectors++; if (underflow !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL areset_flags: uf=%0b of=%0b want 0/0", underflow, overflow); end
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (hdr_valid !== 1'b0) begin miscompares++; $display("FAIL areset_no_valid[%0d]: got %0b want 0", i, hdr_valid); end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_prefill();
        test_stream();
        test_full();
        test_wrap();
        test_simultaneous();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sonic_sync_ring_ctrl.md
# sonic_sync_ring_ctrl

Single-clock read-side controller for the TX sync-header ring: the 128-bit-write / 2-bit-read dual-port buffer in which the DMA channel deposits 64 sync headers per 128-bit word. Tracks committed words against consumed headers and drives the ring's read address for the TX encoder. Provides prefill gating, a registered valid aligned to ring read latency, DMA free-space credit and sticky underflow/overflow flags.

## Interface
- `WR_ADDR_WIDTH`, default 9: 128-bit word address width; ring depth is `2**WR_ADDR_WIDTH` words.
- `RD_ADDR_WIDTH`, default `WR_ADDR_WIDTH+6`: 2-bit header address width. Any other value is illegal.
- `RD_LAT`, default 2: ring read latency from address to `data_out`, in cycles. Legal range 1..4.
- `PREFILL_WORDS`, default 2: committed words required before reads start. Legal range 1..depth.

Ports:
- `clock` in 1: sole clock. It is the ring's read clock; write commits arrive already synchronised.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request from the TX path.
- `clear` in 1: synchronous flush of pointers, flags and state.
- `wr_commit` in 1: one-cycle pulse meaning one further 128-bit word has been written.
- `rd_req` in 1: encoder requests the next 2-bit header.
- `rd_address` out RD_ADDR_WIDTH: header read address driven to the ring.
- `rd_ack` out 1: the `rd_req` in this cycle is accepted (combinational).
- `hdr_valid` out 1: ring `data_out` carries an accepted header this cycle.
- `level` out RD_ADDR_WIDTH+1: unread headers in the ring.
- `free_words` out WR_ADDR_WIDTH+1: words DMA may still write.
- `running` out 1: state is RUN.
- `underflow` out 1: sticky flag.
- `overflow` out 1: sticky flag.

## Operation
Registers:
- `wr_ptr`: WR_ADDR_WIDTH+1 bits.
- `rd_ptr`: RD_ADDR_WIDTH+1 bits.
- All pointer arithmetic is modulo 2^width, using the extra bit for full/empty disambiguation.

Derived quantities:
- `used_words = wr_ptr - rd_ptr[RD_ADDR_WIDTH:6]`. A word is freed only once all 64 of its headers are read.
- `free_words = 2**WR_ADDR_WIDTH - used_words`.
- `level = {wr_ptr,6'b0} - rd_ptr`.
- `rd_address = rd_ptr[RD_ADDR_WIDTH-1:0]`, driven directly from the register.

Write side:
- On `wr_commit`: if `free_words != 0`, `wr_ptr += 1`.
- If `free_words == 0`, `overflow` sets and `wr_ptr` is unchanged.
- Commits are counted in every state.

State machine (2-bit):
- IDLE → FILL when `enable` is high.
- FILL → RUN when `enable` is high and `used_words >= PREFILL_WORDS`.
- RUN → FILL on `rd_req` with `level == 0`. This sets `underflow`; the request is not acked.
- Any state → IDLE when `enable` is low. Pointers are held; in-flight `hdr_valid` still drains.

Read acceptance:
- `rd_ack = running & rd_req & (level != 0)`.
- On ack, `rd_ptr += 1` at the next edge.

Simultaneous events:
- Commit plus ack in the same cycle: both apply; `level` changes by +63.
- Commit while full plus ack in the same cycle: the commit is still rejected. Fullness is evaluated on the pre-edge value.
- `clear` has priority over every other input. It zeroes both pointers, clears both flags, forces IDLE and flushes the valid pipeline.

## Timing
- Reset values: `rd_address=0`, `rd_ack=0`, `hdr_valid=0`, `level=0`, `free_words=2**WR_ADDR_WIDTH`, `running=0`, `underflow=0`, `overflow=0`. State is IDLE.
- `rd_ack` asserted in cycle t: `rd_address` holds that header's address during t, and `hdr_valid` is high in cycle t+RD_LAT.
- `hdr_valid` comes from an RD_LAT-deep shift register of `rd_ack`.
- Back-to-back acks yield one header per cycle.
- Pointer wrap is seamless: address `2**RD_ADDR_WIDTH-1` is followed by address 0.
- `level`, `free_words` and `running` reflect register state after the edge. Their effect on `rd_ack` takes zero additional cycles.
- Reset asserted mid-run clears everything asynchronously, including in-flight valids.

## Configuration
- `SONIC_SYNC_RING_STATS_EN` defined: adds outputs `hdr_count` (32-bit) and `underflow_count` (16-bit), and input `stats_clear`.
  - `hdr_count` counts acks and wraps.
  - `underflow_count` counts underflow events and saturates at 0xFFFF.
  - Both counters reset on `reset_n`, `clear` or `stats_clear`.
- Not defined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Prefill gating: `enable=1`, one commit, `rd_req=1` → no ack, state FILL. Second commit → RUN next cycle; first ack at address 0, `hdr_valid` two cycles later.
- Streaming across word boundary: 2 words committed, 128 consecutive reqs → 128 acks with addresses 0..127. `free_words` returns to 512 after the 128th. Then a further req → `underflow=1` and state FILL.
- Full ring: 512 commits → `free_words=0`, `level=32768`. 513th commit → `overflow=1`, `wr_ptr` unchanged. One read does not free a word; 64 reads give `free_words=1`.
- Wrap-around: cycle 600 words through with continuous reads → address sequence wraps 32767→0 with no gap and `level` is never negative.
- Simultaneous/priority: commit+ack in the same cycle at `level=10` → `level=73`. `clear` together with commit and req → all pointers 0, flags 0, IDLE, no `hdr_valid` afterwards.
- Async reset mid-run with 2 valids in flight → all outputs at reset values immediately. No `hdr_valid` after release.
